// File: rtl/sub2_lane_packer_if.sv
// Byte-stream in / 3-lane group out handshake bundle between the feeder and sub2.
interface sub2_lane_packer_if;
  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_last;
  logic            in_ready;
  logic            out_ready;
  logic            sig_e;
  logic [1:0]      sig_f;
  logic [0:2][7:0] sig_g;
  logic [7:0]      sig_h [3];

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, sig_e, sig_f, sig_g, sig_h
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, sig_e, sig_f, sig_g, sig_h
  );
endinterface

// File: rtl/sub2_lane_packer.sv
// Packs a valid/ready byte stream into 3-byte groups with one output and one pending slot.
// Optional idle flush of partial groups when SUB2_LANE_FLUSH_EN is defined.
module sub2_lane_packer #(
  parameter logic [7:0]  PAD_BYTE     = 8'h00,
  parameter int unsigned FLUSH_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  sub2_lane_packer_if.slave bus
);

  localparam int unsigned LANES = 3;
  typedef logic [0:LANES-1][7:0] lanes_t;

  if (FLUSH_CYCLES < 1) begin : g_bad_flush
    $error("FLUSH_CYCLES must be >= 1");
  end

  logic [1:0]      r_cnt, w_cnt_nxt;
  logic [0:1][7:0] r_acc, w_acc_nxt;
  logic            r_pend, w_pend_nxt;
  logic [1:0]      r_pend_f, w_pend_f_nxt;
  lanes_t          r_pend_g, w_pend_g_nxt;
  logic            r_e, w_e_nxt;
  logic [1:0]      r_f, w_f_nxt;
  lanes_t          r_g, w_g_nxt;

  logic            w_take;
  logic            w_free;
  logic            w_done;
  logic            w_flush;
  lanes_t          w_grp;
  logic [1:0]      w_grp_f;

  assign bus.in_ready = !rst && !(r_pend && !(r_e && bus.out_ready));
  assign w_take       = bus.in_valid && bus.in_ready;
  assign w_free       = !r_e || bus.out_ready;

`ifdef SUB2_LANE_FLUSH_EN
  localparam int unsigned IDLE_W = $clog2(FLUSH_CYCLES + 1);
  logic [IDLE_W-1:0] r_idle;
  logic              w_idle;

  assign w_idle  = (r_cnt != 2'd0) && !r_pend && !w_take;
  assign w_flush = w_idle && (r_idle == IDLE_W'(FLUSH_CYCLES));

  // Idle timer: counts stalled cycles of a partial group, cleared by any accept or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle <= '0;
    end else if (w_take || w_flush) begin
      r_idle <= '0;
    end else if (w_idle) begin
      r_idle <= r_idle + IDLE_W'(1);
    end
  end
`else
  assign w_flush = 1'b0;
`endif

  // Candidate group: stored lanes, the byte being accepted, padding above the count.
  always_comb begin
    w_grp = {LANES{PAD_BYTE}};
    for (int i = 0; i < 2; i++) begin
      if (2'(i) < r_cnt) w_grp[i] = r_acc[i];
    end
    if (w_take) w_grp[r_cnt] = bus.in_data;
    w_grp_f = w_take ? (r_cnt + 2'd1) : r_cnt;
    w_done  = (w_take && (bus.in_last || (r_cnt == 2'd2))) || w_flush;

    w_cnt_nxt = r_cnt;
    w_acc_nxt = r_acc;
    if (w_done) begin
      w_cnt_nxt = 2'd0;
    end else if (w_take) begin
      w_acc_nxt[r_cnt[0]] = bus.in_data;
      w_cnt_nxt           = r_cnt + 2'd1;
    end
  end

  // Output/pending slots: pending always drains first to keep strict completion order.
  always_comb begin
    w_e_nxt      = r_e;
    w_f_nxt      = r_f;
    w_g_nxt      = r_g;
    w_pend_nxt   = r_pend;
    w_pend_f_nxt = r_pend_f;
    w_pend_g_nxt = r_pend_g;
    if (w_free) begin
      if (r_pend) begin
        w_e_nxt    = 1'b1;
        w_f_nxt    = r_pend_f;
        w_g_nxt    = r_pend_g;
        w_pend_nxt = w_done;
        if (w_done) begin
          w_pend_f_nxt = w_grp_f;
          w_pend_g_nxt = w_grp;
        end
      end else if (w_done) begin
        w_e_nxt = 1'b1;
        w_f_nxt = w_grp_f;
        w_g_nxt = w_grp;
      end else if (r_e) begin
        w_e_nxt = 1'b0;
        w_f_nxt = 2'd0;
      end
    end else if (w_done) begin
      w_pend_nxt   = 1'b1;
      w_pend_f_nxt = w_grp_f;
      w_pend_g_nxt = w_grp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 2'd0;
      r_acc    <= '0;
      r_pend   <= 1'b0;
      r_pend_f <= 2'd0;
      r_pend_g <= '0;
      r_e      <= 1'b0;
      r_f      <= 2'd0;
      r_g      <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_pend   <= w_pend_nxt;
      r_pend_f <= w_pend_f_nxt;
      r_pend_g <= w_pend_g_nxt;
      r_e      <= w_e_nxt;
      r_f      <= w_f_nxt;
      r_g      <= w_g_nxt;
    end
  end

  assign bus.sig_e = r_e;
  assign bus.sig_f = r_f;
  assign bus.sig_g = r_g;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_unpack
    assign bus.sig_h[gi] = r_g[gi];
  end

endmodule

// File: tb/tb_sub2_lane_packer.sv
// Scoreboard bench for sub2_lane_packer: directed cases then randomized valid/ready traffic.
module tb_sub2_lane_packer;

  localparam logic [7:0]  PAD   = 8'hA5;
  localparam int unsigned FLUSH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sub2_lane_packer_if bus ();

  sub2_lane_packer #(.PAD_BYTE(PAD), .FLUSH_CYCLES(FLUSH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model state: accumulator and queue of {count, lanes}
  logic [25:0]     sb[$];
  logic [0:2][7:0] m_acc;
  int              m_cnt = 0;
  logic            prev_hold = 1'b0;
  logic [25:0]     prev_word;

  always @(negedge clk) begin
    logic [25:0] w, e;
    if (rst) begin
      sb.delete();
      m_cnt     = 0;
      prev_hold = 1'b0;
    end else begin
      w = {bus.sig_f, bus.sig_g};
      chk("h_eq_g", {8'h0, bus.sig_h[0], bus.sig_h[1], bus.sig_h[2]}, {8'h0, bus.sig_g});
      if (!bus.sig_e) chk("f_zero_idle", 32'(bus.sig_f), 32'd0);
      if (prev_hold) chk("hold", {5'd0, bus.sig_e, w}, {5'd0, 1'b1, prev_word});
      if (bus.sig_e && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_group", 32'(w), 32'h3ffffff);
        end else begin
          e = sb.pop_front();
          chk("group", 32'(w), 32'(e));
        end
      end
      prev_hold = bus.sig_e && !bus.out_ready;
      prev_word = w;
      if (bus.in_valid && bus.in_ready) begin
        m_acc[m_cnt] = bus.in_data;
        m_cnt++;
        if (bus.in_last || m_cnt == 3) begin
          for (int i = 0; i < 3; i++) if (i >= m_cnt) m_acc[i] = PAD;
          sb.push_back({2'(m_cnt), m_acc});
          m_cnt = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    logic ok;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("send_timeout", 32'(ok), 32'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic done_rand = 1'b0;

  initial begin
    int k;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_e", 32'(bus.sig_e), 32'd0);
    chk("rst_f", 32'(bus.sig_f), 32'd0);
    chk("rst_g", 32'(bus.sig_g), 32'd0);
    chk("rst_h", {8'h0, bus.sig_h[0], bus.sig_h[1], bus.sig_h[2]}, 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full group with one-cycle latency
    bus.out_ready = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("t1_e", 32'(bus.sig_e), 32'd1);
    chk("t1_f", 32'(bus.sig_f), 32'd3);
    chk("t1_g", 32'(bus.sig_g), 32'h112233);
    chk("t1_h", {8'h0, bus.sig_h[0], bus.sig_h[1], bus.sig_h[2]}, 32'h112233);
    idle(2);

    // Short groups closed by in_last
    send(8'h44, 1'b1);
    chk("t2_f1", 32'(bus.sig_f), 32'd1);
    chk("t2_g1", 32'(bus.sig_g), 32'h44A5A5);
    send(8'h55, 1'b0);
    send(8'h66, 1'b1);
    chk("t2_f2", 32'(bus.sig_f), 32'd2);
    chk("t2_g2", 32'(bus.sig_g), 32'h5566A5);
    send(8'h67, 1'b0);
    send(8'h68, 1'b0);
    send(8'h69, 1'b1);
    chk("t2_f3", 32'(bus.sig_f), 32'd3);
    idle(2);
    chk("t2_drain", 32'(bus.sig_e), 32'd0);

    // Held output plus pending group, then back-to-back drain
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    chk("t3_held", 32'(bus.sig_g), 32'h010203);
    chk("t3_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_second_e", 32'(bus.sig_e), 32'd1);
    chk("t3_second", 32'(bus.sig_g), 32'h040506);
    @(posedge clk); #1;
    chk("t3_empty", 32'(bus.sig_e), 32'd0);
    chk("t3_keep_g", 32'(bus.sig_g), 32'h040506);

    // Idle flush of a partial group
    bus.out_ready = 1'b0;
    send(8'h5A, 1'b0);
`ifdef SUB2_LANE_FLUSH_EN
    k = 0;
    while (!bus.sig_e && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("flush_lat", 32'(k), 32'(FLUSH + 1));
    chk("flush_f", 32'(bus.sig_f), 32'd1);
    chk("flush_g", 32'(bus.sig_g), 32'h5AA5A5);
    sb.push_back({2'd1, 24'h5AA5A5});
    m_cnt = 0;
    bus.out_ready = 1'b1;
    idle(2);
`else
    k = 0;
    idle(100);
    chk("noflush", 32'(bus.sig_e), 32'd0);
    bus.out_ready = 1'b1;
    send(8'h5B, 1'b1);
    chk("noflush_g", 32'(bus.sig_g), 32'h5A5BA5);
    idle(2);
`endif

    // Reset with a held group and a partial accumulator
    bus.out_ready = 1'b0;
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hB3, 1'b0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    rst = 1'b1;
    #1;
    chk("t4_e", 32'(bus.sig_e), 32'd0);
    chk("t4_f", 32'(bus.sig_f), 32'd0);
    chk("t4_g", 32'(bus.sig_g), 32'd0);
    chk("t4_ready", 32'(bus.in_ready), 32'd0);
    idle(2);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(8'h77, 1'b1);
    chk("t4_post_f", 32'(bus.sig_f), 32'd1);
    chk("t4_post_g", 32'(bus.sig_g), 32'h77A5A5);
    idle(2);

    // Random traffic against the scoreboard
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          send(8'($urandom), ($urandom_range(0, 7) == 0));
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    bus.out_ready = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    idle(2);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
